// File: rtl/rx_majority_voter.sv
// GMII receive-side frame summariser: records first byte, XOR and length of each
// frame into three rotating slots and publishes the 2-of-3 majority record.
module rx_majority_voter (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic        clk,
    input  logic [7:0]  rx_data,
    input  logic        rx_enable,
    input  logic        rx_error,
    input  logic        sfd_wait,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic [7:0]  out1,
    output logic [7:0]  out2,
    output logic [11:0] out3
);

    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [11:0] L_MAX    = 12'hFFF;

    // Record layout: [28] valid, [27:20] first byte, [19:12] xor, [11:0] length
    logic [28:0] r_rec [3];

    logic        r_in_frame;
    logic        r_skip;
    logic        r_hunt;
    logic        r_err;
    logic [7:0]  r_f;
    logic [7:0]  r_x;
    logic [11:0] r_l;
    logic [1:0]  r_slot;
    logic        r_vote;

    logic        w_start;
    logic        w_active;
    logic        w_take;
    logic        w_end;
    logic        w_commit;
    logic        w_m01;
    logic        w_m02;
    logic        w_m12;
    logic        w_has_win;
    logic [28:0] w_win;
    logic        w_unused;

    assign w_unused = &{1'b0, clk, uart_rxd, w_win[28]};
    assign uart_txd = 1'b1;

    // r_skip blocks a frame that was already running when reset was released
    assign w_start  = rx_enable && !r_in_frame && !r_skip;
    assign w_active = rx_enable && r_in_frame;
    assign w_take   = (w_start && !sfd_wait) || (w_active && !r_hunt);
    assign w_end    = !rx_enable && r_in_frame;
    assign w_commit = w_end && (r_l != 12'd0);

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            r_in_frame <= 1'b0;
            r_skip     <= rx_enable;
            r_hunt     <= 1'b0;
            r_err      <= 1'b0;
            r_f        <= 8'h00;
            r_x        <= 8'h00;
            r_l        <= 12'd0;
            r_slot     <= 2'd0;
            r_vote     <= 1'b0;
            out1       <= 8'h00;
            out2       <= 8'h00;
            out3       <= 12'd0;
        end else begin
            r_vote <= w_commit && (r_slot == 2'd2);
            if (!rx_enable) begin
                r_skip <= 1'b0;
            end

            if (w_start) begin
                r_in_frame <= 1'b1;
                r_err      <= rx_error;
                r_hunt     <= sfd_wait && (rx_data != SFD_BYTE);
                r_f        <= rx_data;
                r_x        <= w_take ? rx_data : 8'h00;
                r_l        <= w_take ? 12'd1 : 12'd0;
            end else if (w_active) begin
                r_err <= r_err | rx_error;
                if (r_hunt && (rx_data == SFD_BYTE)) begin
                    r_hunt <= 1'b0;
                end
                if (w_take) begin
                    if (r_l == 12'd0) begin
                        r_f <= rx_data;
                    end
                    r_x <= r_x ^ rx_data;
                    if (r_l != L_MAX) begin
                        r_l <= r_l + 12'd1;
                    end
                end
            end else if (w_end) begin
                r_in_frame <= 1'b0;
                if (w_commit) begin
                    r_slot <= (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;
                end
            end

            if (r_vote && w_has_win) begin
                out1 <= w_win[27:20];
                out2 <= w_win[19:12];
                out3 <= w_win[11:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slot
            always_ff @(posedge rx_clk) begin
                if (reset) begin
                    r_rec[gi] <= '0;
                end else if (w_commit && (r_slot == 2'(gi))) begin
                    r_rec[gi] <= {!r_err, r_f, r_x, r_l};
                end
            end
        end
    endgenerate

    // Invalid records never match, even against an identical invalid record
    assign w_m01 = r_rec[0][28] && r_rec[1][28] && (r_rec[0] == r_rec[1]);
    assign w_m02 = r_rec[0][28] && r_rec[2][28] && (r_rec[0] == r_rec[2]);
    assign w_m12 = r_rec[1][28] && r_rec[2][28] && (r_rec[1] == r_rec[2]);

    always_comb begin
        w_has_win = 1'b0;
        w_win     = r_rec[0];
        if (w_m01 || w_m02) begin
            w_has_win = 1'b1;
            w_win     = r_rec[0];
        end else if (w_m12) begin
            w_has_win = 1'b1;
            w_win     = r_rec[1];
        end
    end

endmodule

// File: tb/tb_rx_majority_voter.sv
// Scoreboard bench for rx_majority_voter: expected vote results are queued when the
// third frame of a triple ends and compared on the cycle the outputs must change.
module tb_rx_majority_voter;

    logic        rx_clk = 1'b0;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_enable = 1'b0;
    logic        rx_error = 1'b0;
    logic        sfd_wait = 1'b0;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;
    logic [7:0]  out1;
    logic [7:0]  out2;
    logic [11:0] out3;

    rx_majority_voter dut (
        .rx_clk    (rx_clk),
        .reset     (reset),
        .clk       (clk),
        .rx_data   (rx_data),
        .rx_enable (rx_enable),
        .rx_error  (rx_error),
        .sfd_wait  (sfd_wait),
        .uart_rxd  (uart_rxd),
        .uart_txd  (uart_txd),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3)
    );

    always #4 rx_clk = ~rx_clk;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       tag;
        logic [7:0]  p1;
        logic [7:0]  p2;
        logic [11:0] p3;
        logic [7:0]  e1;
        logic [7:0]  e2;
        logic [11:0] e3;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  drv_o1 = 8'h00;
    logic [7:0]  drv_o2 = 8'h00;
    logic [11:0] drv_o3 = 12'd0;

    always @(posedge rx_clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs must still show the old result one cycle before the update is due
    always @(negedge rx_clk) begin
        if (sb_q.size() > 0) begin
            if (sb_q[0].due == cyc + 1) begin
                check_val({sb_q[0].tag, "_pre_out1"}, 32'(out1), 32'(sb_q[0].p1));
                check_val({sb_q[0].tag, "_pre_out2"}, 32'(out2), 32'(sb_q[0].p2));
                check_val({sb_q[0].tag, "_pre_out3"}, 32'(out3), 32'(sb_q[0].p3));
            end else if (sb_q[0].due == cyc) begin
                mon_e = sb_q.pop_front();
                check_val({mon_e.tag, "_out1"}, 32'(out1), 32'(mon_e.e1));
                check_val({mon_e.tag, "_out2"}, 32'(out2), 32'(mon_e.e2));
                check_val({mon_e.tag, "_out3"}, 32'(out3), 32'(mon_e.e3));
                $display("[TB] %s: out1=%02h out2=%02h out3=%03h", mon_e.tag, out1, out2, out3);
            end
        end
    end

    // Bytes are packed MSB-first in b; sfd_wait is inverted after the first byte
    // to show it is only sampled at frame start.
    task automatic send_frame(input logic [63:0] b, input int n, input logic sfd,
                              input int err_at, input int gap, input bit push,
                              input bit win, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [11:0] e3, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge rx_clk);
            rx_enable = 1'b1;
            rx_data   = b[8*(n-1-i) +: 8];
            sfd_wait  = (i == 0) ? sfd : ~sfd;
            rx_error  = (i == err_at);
        end
        @(negedge rx_clk);
        rx_enable = 1'b0;
        rx_error  = 1'b0;
        rx_data   = 8'h00;
        if (push) begin
            e.due = cyc + 2;
            e.tag = tag;
            e.p1 = drv_o1; e.p2 = drv_o2; e.p3 = drv_o3;
            if (win) begin
                drv_o1 = e1; drv_o2 = e2; drv_o3 = e3;
            end
            e.e1 = drv_o1; e.e2 = drv_o2; e.e3 = drv_o3;
            sb_q.push_back(e);
        end
        for (int g = 1; g < gap; g++) @(negedge rx_clk);
    endtask

    task automatic send_triple(input logic [63:0] a, input int na, input logic [63:0] b,
                               input int nb, input logic [63:0] c, input int nc,
                               input logic sfd, input int ea, input int eb, input int ec,
                               input int gap, input bit win, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [11:0] e3, input string tag);
        send_frame(a, na, sfd, ea, gap, 1'b0, 1'b0, 8'h0, 8'h0, 12'h0, tag);
        send_frame(b, nb, sfd, eb, gap, 1'b0, 1'b0, 8'h0, 8'h0, 12'h0, tag);
        send_frame(c, nc, sfd, ec, gap, 1'b1, win, e1, e2, e3, tag);
    endtask

    initial begin
        repeat (3) @(negedge rx_clk);
        check_val("rst_out1", 32'(out1), 32'h00);
        check_val("rst_uart_txd", 32'(uart_txd), 32'h1);
        reset = 1'b0;
        @(negedge rx_clk);
        check_val("rst_out2", 32'(out2), 32'h00);
        check_val("rst_out3", 32'(out3), 32'h000);
        check_val("idle_uart_txd", 32'(uart_txd), 32'h1);

        send_triple(64'hDEADBEEF, 4, 64'hDEADBEEF, 4, 64'hDEADBEEF, 4, 1'b0, -1, -1, -1,
                    4, 1'b1, 8'hDE, 8'h22, 12'h004, "all_same");
        send_triple(64'hDEADBEEF, 4, 64'hDEADBEEE, 4, 64'hDEADBEEE, 4, 1'b0, -1, -1, -1,
                    4, 1'b1, 8'hDE, 8'h23, 12'h004, "slot1_wins");
        send_triple(64'h0102, 2, 64'h03, 1, 64'h040506, 3, 1'b0, -1, -1, -1,
                    3, 1'b0, 8'h00, 8'h00, 12'h000, "no_winner");

        send_frame(64'h5555D51234, 5, 1'b1, -1, 3, 1'b0, 1'b0, 8'h0, 8'h0, 12'h0, "sfd");
        send_frame(64'h555512, 3, 1'b1, -1, 3, 1'b0, 1'b0, 8'h0, 8'h0, 12'h0, "sfd");
        send_frame(64'h5555D51234, 5, 1'b1, -1, 3, 1'b0, 1'b0, 8'h0, 8'h0, 12'h0, "sfd");
        send_frame(64'h5555D51234, 5, 1'b1, -1, 3, 1'b1, 1'b1, 8'h12, 8'h26, 12'h002, "sfd");

        send_triple(64'h1122, 2, 64'h1122, 2, 64'h1122, 2, 1'b0, 0, 1, -1,
                    3, 1'b0, 8'h00, 8'h00, 12'h000, "err_two");
        send_triple(64'h1122, 2, 64'h33, 1, 64'h1122, 2, 1'b0, -1, -1, -1,
                    1, 1'b1, 8'h11, 8'h33, 12'h002, "gap1_slot0_wins");
        send_triple(64'hD57E, 2, 64'hD57E, 2, 64'hD57E, 2, 1'b1, -1, -1, -1,
                    1, 1'b1, 8'h7E, 8'h7E, 12'h001, "sfd_first_byte");

        repeat (4) @(negedge rx_clk);
        send_frame(64'hDEADBEEF, 4, 1'b0, -1, 2, 1'b0, 1'b0, 8'h0, 8'h0, 12'h0, "mid_rst");
        @(negedge rx_clk); rx_enable = 1'b1; rx_data = 8'hDE; sfd_wait = 1'b0;
        @(negedge rx_clk); rx_data = 8'hAD;
        @(negedge rx_clk); rx_data = 8'hBE; reset = 1'b1;
        @(negedge rx_clk); rx_data = 8'hEF; reset = 1'b0;
        @(negedge rx_clk); rx_enable = 1'b0; rx_data = 8'h00;
        check_val("mid_rst_out1", 32'(out1), 32'h00);
        check_val("mid_rst_out2", 32'(out2), 32'h00);
        check_val("mid_rst_out3", 32'(out3), 32'h000);
        drv_o1 = 8'h00; drv_o2 = 8'h00; drv_o3 = 12'd0;
        repeat (2) @(negedge rx_clk);
        send_triple(64'hDEADBEEF, 4, 64'hDEADBEEF, 4, 64'hDEADBEEF, 4, 1'b0, -1, -1, -1,
                    4, 1'b1, 8'hDE, 8'h22, 12'h004, "after_rst");

        for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(negedge rx_clk);
        check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
